legv8_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the LEGv8 datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives the Reg2Loc select of the register-file read-port-2 mux, plus ALU, memory, PC and writeback controls.
- Sits between the instruction register's opcode field and the datapath muxes/enables; handshakes with data memory through MemReady.

---
 rtl/legv8_multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch, decode, execute, memory and writeback sequencing.
// Optional LEGV8_CTRL_PERF_EN adds RetireCount/StallCount performance counters.
module legv8_multicycle_ctrl #(
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned MEM_WAIT_MAX    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Retire,
    output logic        Halted
`ifdef LEGV8_CTRL_PERF_EN
    ,
    output logic [31:0] RetireCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ClsNone, ClsR, ClsLdur, ClsStur, ClsCbz, ClsB, ClsIll
    } cls_t;

    localparam logic [8:0] WaitMax = 9'(MEM_WAIT_MAX);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    cls_t       dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       timeout;

    function automatic cls_t classify(input logic [10:0] op);
        cls_t c;
        casez (op)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: c = ClsR;
            11'b11111000010: c = ClsLdur;
            11'b11111000000: c = ClsStur;
            11'b10110100???: c = ClsCbz;
            11'b000101?????: c = ClsB;
            default:         c = ClsIll;
        endcase
        return c;
    endfunction

    assign dec_cls = classify(Opcode);
    assign timeout = (WaitMax != 9'd0) && (({1'b0, wait_q} + 9'd1) >= WaitMax);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        wait_d   = 8'd0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Retire   = 1'b0;
        Halted   = 1'b0;
        unique case (state_q)
            StFetch: begin
                IRWrite = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                // The class register is only loaded at the end of DECODE, so the
                // read-port-2 select is taken straight from the opcode here.
                cls_d   = dec_cls;
                Reg2Loc = (dec_cls == ClsStur) || (dec_cls == ClsCbz);
                state_d = (dec_cls == ClsIll && HALT_ON_ILLEGAL) ? StHalt : StExec;
            end
            StExec: begin
                Reg2Loc = (cls_q == ClsStur) || (cls_q == ClsCbz);
                case (cls_q)
                    ClsR: begin
                        ALUOp   = 2'b10;
                        state_d = StWb;
                    end
                    ClsLdur, ClsStur: begin
                        ALUSrc  = 1'b1;
                        state_d = StMem;
                    end
                    ClsCbz: begin
                        ALUOp   = 2'b01;
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                        Retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsB: begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                        Retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: begin
                        PCWrite = 1'b1;
                        Retire  = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                ALUSrc   = 1'b1;
                Reg2Loc  = (cls_q == ClsStur);
                MemRead  = (cls_q == ClsLdur);
                MemWrite = (cls_q == ClsStur);
                if (MemReady) begin
                    if (cls_q == ClsStur) begin
                        PCWrite = 1'b1;
                        Retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StHalt;
                end else begin
                    wait_d  = wait_q + 8'd1;
                    state_d = StMem;
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                Retire   = 1'b1;
                MemtoReg = (cls_q == ClsLdur);
                state_d  = StFetch;
            end
            StHalt: begin
                Halted  = 1'b1;
                state_d = StHalt;
            end
            default: state_d = StFetch;
        endcase
    end

`ifdef LEGV8_CTRL_PERF_EN
    logic [31:0] retire_cnt_q, stall_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retire_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            if (Retire) retire_cnt_q <= retire_cnt_q + 32'd1;
            if (state_q == StMem && !MemReady) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign RetireCount = retire_cnt_q;
    assign StallCount  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench for legv8_multicycle_ctrl: directed vector table, reset corner case and
// randomized instruction stream against an instruction-level reference model.
module tb_legv8_multicycle_ctrl;

    localparam int MAXW = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] Opcode = 11'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        Reg2Loc, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic        IRWrite, PCWrite, PCSrc, Retire, Halted;
    logic [1:0]  ALUOp;
`ifdef LEGV8_CTRL_PERF_EN
    logic [31:0] RetireCount, StallCount;
`endif

    legv8_multicycle_ctrl #(
        .HALT_ON_ILLEGAL(1'b1),
        .MEM_WAIT_MAX   (MAXW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Opcode  (Opcode),
        .Zero    (Zero),
        .MemReady(MemReady),
        .Reg2Loc (Reg2Loc),
        .ALUSrc  (ALUSrc),
        .ALUOp   (ALUOp),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .MemtoReg(MemtoReg),
        .RegWrite(RegWrite),
        .IRWrite (IRWrite),
        .PCWrite (PCWrite),
        .PCSrc   (PCSrc),
        .Retire  (Retire),
        .Halted  (Halted)
`ifdef LEGV8_CTRL_PERF_EN
        ,
        .RetireCount(RetireCount),
        .StallCount (StallCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef enum int {KR, KLdur, KStur, KCbz, KB, KIll} kind_t;

    typedef struct {
        string       nm;
        logic [10:0] op;
        logic        z;
        int          w;
        int          exp_ret;
        bit          exp_halt;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cur_cyc;
    int act_ret_cyc;
    int exp_retires = 0;
    int exp_stalls = 0;

    wire [12:0] dut_out = {Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite,
                           IRWrite, PCWrite, PCSrc, Retire, Halted};

    function automatic logic [12:0] pack(input logic r2l, input logic als, input logic [1:0] aop,
                                         input logic mr, input logic mw, input logic m2r,
                                         input logic rw, input logic irw, input logic pcw,
                                         input logic pcs, input logic ret, input logic hlt);
        return {r2l, als, aop, mr, mw, m2r, rw, irw, pcw, pcs, ret, hlt};
    endfunction

    function automatic kind_t classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return KR;
        if (op == 11'b11111000010) return KLdur;
        if (op == 11'b11111000000) return KStur;
        if (op[10:3] == 8'b10110100) return KCbz;
        if (op[10:5] == 6'b000101) return KB;
        return KIll;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance past the next rising edge.
    task automatic step(input string nm, input logic [12:0] exp);
        cur_cyc++;
        @(negedge Clk);
        check(nm, {19'd0, dut_out}, {19'd0, exp});
        if (Retire && act_ret_cyc == 0) act_ret_cyc = cur_cyc;
        if (exp[1]) exp_retires++;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_perf(input string nm);
`ifdef LEGV8_CTRL_PERF_EN
        check({nm, "/retire_count"}, RetireCount, exp_retires);
        check({nm, "/stall_count"}, StallCount, exp_stalls);
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        check("reset/outputs", {19'd0, dut_out}, {19'd0, pack(0,0,2'b00,0,0,0,0,1,0,0,0,0)});
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_retires = 0;
        exp_stalls = 0;
    endtask

    task automatic run_instr(input string nm, input logic [10:0] op, input logic z, input int w);
        kind_t k;
        bit    ready;
        int    j;
        k = classify(op);
        cur_cyc = 0;
        act_ret_cyc = 0;
        Opcode = 11'($urandom); MemReady = 1'($urandom); Zero = 1'($urandom);
        step({nm, "/fetch"}, pack(0,0,2'b00,0,0,0,0,1,0,0,0,0));
        Opcode = op;
        step({nm, "/decode"}, pack(k == KStur || k == KCbz,0,2'b00,0,0,0,0,0,0,0,0,0));
        Opcode = 11'($urandom);
        if (k == KIll) begin
            step({nm, "/halt"}, pack(0,0,2'b00,0,0,0,0,0,0,0,0,1));
            return;
        end
        Zero = z;
        case (k)
            KR:          step({nm, "/exec"}, pack(0,0,2'b10,0,0,0,0,0,0,0,0,0));
            KCbz:        step({nm, "/exec"}, pack(1,0,2'b01,0,0,0,0,0,1,z,1,0));
            KB:          step({nm, "/exec"}, pack(0,0,2'b00,0,0,0,0,0,1,1,1,0));
            KLdur:       step({nm, "/exec"}, pack(0,1,2'b00,0,0,0,0,0,0,0,0,0));
            default:     step({nm, "/exec"}, pack(1,1,2'b00,0,0,0,0,0,0,0,0,0));
        endcase
        if (k == KCbz || k == KB) return;
        if (k == KLdur || k == KStur) begin
            j = 0;
            while (1) begin
                ready = (j >= w);
                MemReady = ready; Zero = 1'($urandom); Opcode = 11'($urandom);
                if (!ready) exp_stalls++;
                step({nm, "/mem"}, pack(k == KStur,1,2'b00,k == KLdur,k == KStur,0,0,0,
                                         k == KStur && ready,0,k == KStur && ready,0));
                if (ready) begin
                    if (k == KStur) return;
                    break;
                end
                if (j + 1 >= MAXW) begin
                    MemReady = 1'($urandom);
                    step({nm, "/timeout_halt"}, pack(0,0,2'b00,0,0,0,0,0,0,0,0,1));
                    return;
                end
                j++;
            end
        end
        MemReady = 1'($urandom);
        step({nm, "/wb"}, pack(0,0,2'b00,0,0,k == KLdur,1,0,1,0,1,0));
    endtask

    // Applies one instruction, then checks latency or HALT and resynchronises after a halt.
    task automatic apply(input string nm, input logic [10:0] op, input logic z, input int w,
                         input int exp_ret, input bit exp_halt);
        run_instr(nm, op, z, w);
        if (exp_halt) begin
            check({nm, "/halted"}, {31'd0, Halted}, 32'd1);
            for (int i = 0; i < 2; i++) begin
                Opcode = 11'($urandom); MemReady = 1'($urandom); Zero = 1'($urandom);
                step({nm, "/halt_hold"}, pack(0,0,2'b00,0,0,0,0,0,0,0,0,1));
            end
            check_perf(nm);
            do_reset();
        end else begin
            check({nm, "/latency"}, act_ret_cyc, exp_ret);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",    11'b10001011000, 1'b0, 0, 4, 1'b0});
        vecs.push_back('{"sub",    11'b11001011000, 1'b1, 0, 4, 1'b0});
        vecs.push_back('{"and",    11'b10001010000, 1'b0, 0, 4, 1'b0});
        vecs.push_back('{"orr",    11'b10101010000, 1'b1, 0, 4, 1'b0});
        vecs.push_back('{"ldur_w3", 11'b11111000010, 1'b0, 3, 8, 1'b0});
        vecs.push_back('{"ldur_w0", 11'b11111000010, 1'b0, 0, 5, 1'b0});
        vecs.push_back('{"stur_w0", 11'b11111000000, 1'b0, 0, 4, 1'b0});
        vecs.push_back('{"stur_w2", 11'b11111000000, 1'b1, 2, 6, 1'b0});
        vecs.push_back('{"cbz_z1", 11'b10110100101, 1'b1, 0, 3, 1'b0});
        vecs.push_back('{"cbz_z0", 11'b10110100101, 1'b0, 0, 3, 1'b0});
        vecs.push_back('{"b",      11'b00010110011, 1'b0, 0, 3, 1'b0});
        vecs.push_back('{"ill_7ff", 11'h7FF,        1'b0, 0, 0, 1'b1});
        vecs.push_back('{"ill_near_add", 11'b10001011001, 1'b0, 0, 0, 1'b1});
        vecs.push_back('{"ldur_timeout", 11'b11111000010, 1'b0, 6, 0, 1'b1});
        vecs.push_back('{"stur_timeout", 11'b11111000000, 1'b0, 4, 0, 1'b1});

        #2;
        do_reset();
        foreach (vecs[i])
            apply(vecs[i].nm, vecs[i].op, vecs[i].z, vecs[i].w, vecs[i].exp_ret, vecs[i].exp_halt);
        check_perf("table");

        // Reset asserted between edges while an LDUR waits in MEM.
        do_reset();
        cur_cyc = 0;
        act_ret_cyc = 0;
        step("rst_mid/fetch", pack(0,0,2'b00,0,0,0,0,1,0,0,0,0));
        Opcode = 11'b11111000010;
        step("rst_mid/decode", pack(0,0,2'b00,0,0,0,0,0,0,0,0,0));
        step("rst_mid/exec", pack(0,1,2'b00,0,0,0,0,0,0,0,0,0));
        MemReady = 1'b0;
        @(negedge Clk);
        check("rst_mid/memread", {19'd0, dut_out}, {19'd0, pack(0,1,2'b00,1,0,0,0,0,0,0,0,0)});
        #2 Reset = 1'b1;
        #1 check("rst_mid/async", {19'd0, dut_out}, {19'd0, pack(0,0,2'b00,0,0,0,0,1,0,0,0,0)});
        @(posedge Clk);
        #1 Reset = 1'b0;
        exp_retires = 0;
        exp_stalls = 0;
        Opcode = 11'b10001011000;
        @(negedge Clk);
        check("rst_mid/fetch_after", {19'd0, dut_out}, {19'd0, pack(0,0,2'b00,0,0,0,0,1,0,0,0,0)});
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_mid/decode_after", {19'd0, dut_out}, {19'd0, 13'd0});
        @(posedge Clk);
        #1;
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            logic [10:0] op;
            int          w;
            int          exp_ret;
            bit          exp_halt;
            kind_t       k;
            case ($urandom_range(0, 6))
                0: begin
                    op = 11'b10001011000;
                    case ($urandom_range(0, 3))
                        0: op = 11'b11001011000;
                        1: op = 11'b10001010000;
                        2: op = 11'b10101010000;
                        default: ;
                    endcase
                end
                1, 2: op = 11'b11111000010;
                3: op = 11'b11111000000;
                4: op = {8'b10110100, 3'($urandom)};
                5: op = {6'b000101, 5'($urandom)};
                default: op = 11'($urandom);
            endcase
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            k = classify(op);
            exp_halt = (k == KIll) || ((k == KLdur || k == KStur) && w >= MAXW);
            case (k)
                KR:      exp_ret = 4;
                KLdur:   exp_ret = 5 + w;
                KStur:   exp_ret = 4 + w;
                default: exp_ret = 3;
            endcase
            apply("rand", op, 1'($urandom), w, exp_ret, exp_halt);
        end
        check_perf("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
